gmii_tx_sched: RTL and testbench
================================

Name: gmii_tx_sched

Overview:
- Frame scheduler in front of gmii_tx; shares the single GMII transmit path between the 48-bit video line FIFO and the 12-bit audio/aux FIFO.
- Watches FIFO fill levels and the audio-data-enable window.
- Decides which source the next Ethernet frame carries and how many words it takes.
- Issues one start command per frame, waits for frame completion, then enforces the inter-frame gap.

Parameters:
- VBURST, 160, video words (48-bit, two pixels each) per video frame.
- ABURST, 8, audio words needed for a full audio frame.
- IFG_CYC, 12, minimum idle sys_clk cycles between frame done and next start.
- TIMEOUT, 4095, max cycles in WAIT before abort.

Ports:
- sys_clk  in  1  scheduler clock (125 MHz, same domain as gmii_tx tx_clk).
- sys_rst  in  1  reset, asynchronous, active-high.
- v_empty  in  1  video FIFO empty (read side).
- v_count  in  11  video FIFO read-side data count.
- a_empty  in  1  audio FIFO empty.
- a_count  in  8  audio FIFO read-side data count.
- adesig  in  1  audio window active (already synchronised to sys_clk).
- tx_done  in  1  one-cycle pulse from gmii_tx: frame fully transmitted.
- start  out  1  one-cycle frame start command.
- sel  out  1  source for the frame: 0 = video, 1 = audio; held from start until done.
- len  out  11  word count for the frame; held with sel.
- busy  out  1  high from ISSUE through GAP.
- err_timeout  out  1  sticky; set on WAIT timeout.
- v_frames  out  16  video frames issued (wraps).
- a_frames  out  16  audio frames issued (wraps).

Behaviour:
- Reset values: start=0, sel=0, len=0, busy=0, err_timeout=0, v_frames=0, a_frames=0; state=IDLE, last_sel=1, a_flush=0.
- Eligibility, combinational, evaluated only in IDLE:
  - v_elig = !v_empty && v_count >= VBURST.
  - a_elig = !a_empty && (a_count >= ABURST || a_flush).
- a_flush: set on the registered falling edge of adesig when a_empty=0. Cleared when an audio frame is issued or a_empty=1.
- Arbitration in IDLE:
  - Only one source eligible: grant it.
  - Both eligible: grant the source opposite last_sel (round-robin), so the first tie after reset goes to video.
  - Neither eligible: stay in IDLE.
- ISSUE (1 cycle):
  - start=1, busy=1, last_sel<=sel.
  - Video: len=VBURST. Audio: len=min(a_count, ABURST), zero-extended.
  - Increment the matching frame counter.
  - Next state WAIT.
- Decision-to-start latency: sel/len register on the IDLE->ISSUE edge; start asserts the cycle after eligibility is seen.
- WAIT:
  - tx_done=1 -> GAP.
  - Cycle counter reaches TIMEOUT -> err_timeout<=1, then GAP.
  - tx_done outside WAIT is ignored. tx_done in the same cycle as ISSUE is ignored.
- GAP: count IFG_CYC cycles, then IDLE with busy=0. Eligibility is not sampled during GAP, so no new start can occur earlier than IFG_CYC+1 cycles after done.
- sel/len stay stable from ISSUE until the next ISSUE.
- Counters: 16-bit, wrap at 0xFFFF->0. err_timeout is cleared only by reset.
- Reset mid-frame: immediate return to IDLE. The partial frame is not counted again; gmii_tx shares sys_rst.
- Widths: len computed on 11 bits. a_count compare is unsigned 8-bit. v_count compare is unsigned 11-bit.

Decomposition:
- Shared package gmii_pkg holds:
  - State encoding (IDLE, ISSUE, WAIT, GAP).
  - SEL_VIDEO/SEL_AUDIO constants.
  - Default VBURST/ABURST/IFG_CYC values, shared with gmii_tx.
- Optional sub-module sched_rr2: the 2-requester round-robin picker (req[1:0], last -> gnt).

Test Plan:
- Reset, v_count=200, a_empty=1 -> start pulses with sel=0, len=160; v_frames=1; after tx_done, exactly 12 idle cycles, then start again.
- v_count=200 and a_count=10 both eligible continuously -> grants alternate video, audio, video; audio len=8.
- a_count=3, adesig high then falls -> a_flush set; next start has sel=1, len=3; a_flush clears.
- Start issued, tx_done never arrives -> after 4095 WAIT cycles err_timeout=1, GAP, then IDLE; err_timeout stays 1.
- sys_rst asserted asynchronously mid-WAIT -> start/busy drop immediately, counters read 0, state IDLE; after release the first tie grants video.
- Spurious tx_done pulse in IDLE and in GAP -> no state change, no counter change, no early start.

Source files
------------

// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII transmit path: scheduler state encoding,
// source select codes and the burst/gap defaults also used by gmii_tx.
package gmii_pkg;

  localparam int unsigned DEF_VBURST  = 160;
  localparam int unsigned DEF_ABURST  = 8;
  localparam int unsigned DEF_IFG_CYC = 12;
  localparam int unsigned DEF_TIMEOUT = 4095;

  localparam logic SEL_VIDEO = 1'b0;
  localparam logic SEL_AUDIO = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } sched_state_e;

  // An audio frame carries whatever is queued, capped at one full burst.
  function automatic logic [10:0] audio_len(input logic [7:0] count, input logic [7:0] burst);
    return (count < burst) ? {3'b000, count} : {3'b000, burst};
  endfunction

endpackage

// File: rtl/sched_rr2.sv
// Two-requester round-robin picker: bit 0 is video, bit 1 is audio; on a tie
// the requester that was not served last wins.
module sched_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/gmii_tx_sched.sv
// Frame scheduler sharing one GMII transmit path between the video line FIFO
// and the audio/aux FIFO: pick a source, issue a start, wait for done, hold the gap.
module gmii_tx_sched
  import gmii_pkg::*;
#(
  parameter int unsigned VBURST  = DEF_VBURST,
  parameter int unsigned ABURST  = DEF_ABURST,
  parameter int unsigned IFG_CYC = DEF_IFG_CYC,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        v_empty_i,
  input  logic [10:0] v_count_i,
  input  logic        a_empty_i,
  input  logic [7:0]  a_count_i,
  input  logic        adesig_i,
  input  logic        tx_done_i,
  output logic        start_o,
  output logic        sel_o,
  output logic [10:0] len_o,
  output logic        busy_o,
  output logic        err_timeout_o,
  output logic [15:0] v_frames_o,
  output logic [15:0] a_frames_o
);

  localparam logic [10:0] VBURST_W     = 11'(VBURST);
  localparam logic [7:0]  ABURST_W     = 8'(ABURST);
  localparam logic [11:0] IFG_LAST     = 12'(IFG_CYC - 1);
  localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT - 1);

  sched_state_e state_q;
  logic [11:0]  cnt_q;
  logic         start_q;
  logic         sel_q;
  logic [10:0]  len_q;
  logic         busy_q;
  logic         err_q;
  logic [15:0]  vfr_q;
  logic [15:0]  afr_q;
  logic         last_sel_q;
  logic         adesig_q;
  logic         a_flush_q;
  logic         a_flush_d;

  logic         v_elig;
  logic         a_elig;
  logic [1:0]   gnt;
  logic         a_fall;
  logic         audio_grant;

  assign v_elig      = !v_empty_i && (v_count_i >= VBURST_W);
  assign a_elig      = !a_empty_i && ((a_count_i >= ABURST_W) || a_flush_q);
  assign a_fall      = adesig_q && !adesig_i;
  assign audio_grant = (state_q == S_IDLE) && gnt[1];

  sched_rr2 u_rr (
    .req_i  ({a_elig, v_elig}),
    .last_i (last_sel_q),
    .gnt_o  (gnt)
  );

  // A closing audio window lets a short tail go out instead of waiting for a full burst.
  always_comb begin
    a_flush_d = a_flush_q;
    if (a_empty_i) begin
      a_flush_d = 1'b0;
    end else if (a_fall) begin
      a_flush_d = 1'b1;
    end else if (audio_grant) begin
      a_flush_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      sel_q      <= SEL_VIDEO;
      len_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      vfr_q      <= '0;
      afr_q      <= '0;
      last_sel_q <= SEL_AUDIO;
      adesig_q   <= 1'b0;
      a_flush_q  <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      adesig_q  <= adesig_i;
      a_flush_q <= a_flush_d;
      unique case (state_q)
        S_IDLE: begin
          if (|gnt) begin
            sel_q      <= gnt[1];
            last_sel_q <= gnt[1];
            len_q      <= gnt[1] ? audio_len(a_count_i, ABURST_W) : VBURST_W;
            if (gnt[1]) begin
              afr_q <= afr_q + 16'd1;
            end else begin
              vfr_q <= vfr_q + 16'd1;
            end
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done_i) begin
            cnt_q   <= '0;
            state_q <= S_GAP;
          end else if (cnt_q == TIMEOUT_LAST) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        S_GAP: begin
          // Inputs are not looked at here, so the gap cannot be shortened.
          if (cnt_q == IFG_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_o       = start_q;
  assign sel_o         = sel_q;
  assign len_o         = len_q;
  assign busy_o        = busy_q;
  assign err_timeout_o = err_q;
  assign v_frames_o    = vfr_q;
  assign a_frames_o    = afr_q;

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Bench for gmii_tx_sched: a timestamp-based frame model checked every cycle,
// plus directed scenarios with hand-computed latencies and grant orders.
module tb_gmii_tx_sched;

  localparam int VB  = 160;
  localparam int AB  = 8;
  localparam int IFG = 12;
  localparam int TMO = 4095;

  logic        sysClk = 1'b0;
  logic        sysRst = 1'b0;
  logic        vEmpty = 1'b1;
  logic [10:0] vCount = '0;
  logic        aEmpty = 1'b1;
  logic [7:0]  aCount = '0;
  logic        adesig = 1'b0;
  logic        txDone = 1'b0;
  logic        start_o, sel_o, busy_o, err_timeout_o;
  logic [10:0] len_o;
  logic [15:0] v_frames_o, a_frames_o;

  int  checks = 0;
  int  errors = 0;
  bit  armed  = 1'b0;

  // Model state: a frame is described by its decision edge and its end edge.
  int  edgeN, mDec, mEnd;
  bit  mActive, mStart, mSel, mBusy, mErr, mLastSel, mFlush, mPrevAd;
  int  mLen, mVf, mAf;

  always #4 sysClk = ~sysClk;

  gmii_tx_sched dut (
    .sys_clk_i     (sysClk),
    .sys_rst_i     (sysRst),
    .v_empty_i     (vEmpty),
    .v_count_i     (vCount),
    .a_empty_i     (aEmpty),
    .a_count_i     (aCount),
    .adesig_i      (adesig),
    .tx_done_i     (txDone),
    .start_o       (start_o),
    .sel_o         (sel_o),
    .len_o         (len_o),
    .busy_o        (busy_o),
    .err_timeout_o (err_timeout_o),
    .v_frames_o    (v_frames_o),
    .a_frames_o    (a_frames_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit ve, input int vc, input bit ae, input int ac, input bit ad);
    vEmpty = ve;
    vCount = 11'(vc);
    aEmpty = ae;
    aCount = 8'(ac);
    adesig = ad;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic pulseDone();
    txDone = 1'b1;
    @(negedge sysClk);
    txDone = 1'b0;
  endtask

  task automatic waitStart(input int maxCyc, input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge sysClk);
      cyc++;
    end while (start_o !== 1'b1 && cyc < maxCyc);
    checkOutput({tag, "_start_seen"}, 32'(start_o), 32'd1);
  endtask

  task automatic resetDut();
    sysRst = 1'b1;
    waitCycles(3);
    checkOutput("rst_start", 32'(start_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_len", 32'(len_o), 32'd0);
    checkOutput("rst_vframes", 32'(v_frames_o), 32'd0);
    sysRst = 1'b0;
  endtask

  // Behavioural model: decide on idle edges, then derive everything from edge distances.
  initial begin
    bit fall, vEl, aEl, pickA;
    forever begin
      @(posedge sysClk or posedge sysRst);
      if (sysRst) begin
        edgeN = 0; mDec = 0; mEnd = -1; mActive = 0; mStart = 0; mSel = 0;
        mBusy = 0; mErr = 0; mLastSel = 1; mFlush = 0; mPrevAd = 0;
        mLen = 0; mVf = 0; mAf = 0;
      end else begin
        edgeN++;
        fall    = mPrevAd && !adesig;
        mPrevAd = adesig;
        mStart  = 0;
        pickA   = 0;
        if (!mActive) begin
          vEl = !vEmpty && int'(vCount) >= VB;
          aEl = !aEmpty && (int'(aCount) >= AB || mFlush);
          if (vEl || aEl) begin
            pickA    = (vEl && aEl) ? !mLastSel : aEl;
            mSel     = pickA;
            mLastSel = pickA;
            mLen     = pickA ? ((int'(aCount) < AB) ? int'(aCount) : AB) : VB;
            if (pickA) mAf = (mAf + 1) % 65536; else mVf = (mVf + 1) % 65536;
            mStart  = 1;
            mBusy   = 1;
            mActive = 1;
            mDec    = edgeN;
            mEnd    = -1;
          end
        end else if (mEnd < 0) begin
          if (edgeN >= mDec + 2) begin
            if (txDone) mEnd = edgeN;
            else if (edgeN - mDec - 1 == TMO) begin
              mEnd = edgeN;
              mErr = 1;
            end
          end
        end else if (edgeN == mEnd + IFG) begin
          mActive = 0;
          mBusy   = 0;
        end
        if (aEmpty) mFlush = 0;
        else if (fall) mFlush = 1;
        else if (pickA) mFlush = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge sysClk);
      if (armed && sysRst === 1'b0) begin
        checkOutput("m_start", 32'(start_o), 32'(mStart));
        checkOutput("m_sel", 32'(sel_o), 32'(mSel));
        checkOutput("m_len", 32'(len_o), 32'(mLen));
        checkOutput("m_busy", 32'(busy_o), 32'(mBusy));
        checkOutput("m_err", 32'(err_timeout_o), 32'(mErr));
        checkOutput("m_vframes", 32'(v_frames_o), 32'(mVf));
        checkOutput("m_aframes", 32'(a_frames_o), 32'(mAf));
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int k;
    int n;
    int sels[3];
    int lens[3];
    #1;
    armed = 1'b1;
    resetDut();

    $display("[TB] video only, gap timing");
    applyStimulus(0, 200, 1, 0, 0);
    waitStart(20, "v1", k);
    checkOutput("v1_latency", 32'(k), 32'd1);
    checkOutput("v1_sel", 32'(sel_o), 32'd0);
    checkOutput("v1_len", 32'(len_o), 32'd160);
    checkOutput("v1_vframes", 32'(v_frames_o), 32'd1);
    waitCycles(4);
    pulseDone();
    waitStart(40, "v2", k);
    checkOutput("v2_after_done", 32'(k), 32'd13);
    checkOutput("v2_vframes", 32'(v_frames_o), 32'd2);
    applyStimulus(1, 200, 1, 0, 0);
    waitCycles(3);
    pulseDone();
    waitCycles(15);
    checkOutput("v2_idle_busy", 32'(busy_o), 32'd0);

    $display("[TB] round robin on a tie");
    resetDut();
    applyStimulus(0, 200, 0, 10, 0);
    for (int i = 0; i < 3; i++) begin
      waitStart(40, "rr", k);
      sels[i] = int'(sel_o);
      lens[i] = int'(len_o);
      if (i == 2) applyStimulus(1, 200, 1, 10, 0);
      waitCycles(2);
      pulseDone();
    end
    waitCycles(15);
    checkOutput("rr_sel0", 32'(sels[0]), 32'd0);
    checkOutput("rr_sel1", 32'(sels[1]), 32'd1);
    checkOutput("rr_sel2", 32'(sels[2]), 32'd0);
    checkOutput("rr_len1", 32'(lens[1]), 32'd8);
    checkOutput("rr_len2", 32'(lens[2]), 32'd160);
    checkOutput("rr_aframes", 32'(a_frames_o), 32'd1);

    $display("[TB] audio flush on window close");
    applyStimulus(1, 0, 0, 3, 1);
    waitCycles(4);
    checkOutput("fl_no_start", 32'(busy_o), 32'd0);
    applyStimulus(1, 0, 0, 3, 0);
    waitStart(10, "fl", k);
    checkOutput("fl_latency", 32'(k), 32'd2);
    checkOutput("fl_sel", 32'(sel_o), 32'd1);
    checkOutput("fl_len", 32'(len_o), 32'd3);
    waitCycles(2);
    pulseDone();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sysClk);
      if (start_o === 1'b1) n++;
    end
    checkOutput("fl_cleared", 32'(n), 32'd0);
    applyStimulus(1, 0, 1, 0, 0);

    $display("[TB] spurious done pulses");
    pulseDone();
    waitCycles(2);
    checkOutput("sp_idle_busy", 32'(busy_o), 32'd0);
    checkOutput("sp_idle_vframes", 32'(v_frames_o), 32'd2);
    checkOutput("sp_idle_aframes", 32'(a_frames_o), 32'd2);
    applyStimulus(0, 200, 1, 0, 0);
    waitStart(20, "sp", k);
    pulseDone();
    waitCycles(3);
    checkOutput("sp_issue_ignored", 32'(busy_o), 32'd1);
    pulseDone();
    waitCycles(4);
    pulseDone();
    waitStart(40, "sp2", k);
    checkOutput("sp_gap_ignored", 32'(k), 32'd8);
    applyStimulus(1, 200, 1, 0, 0);
    waitCycles(3);
    pulseDone();
    waitCycles(15);

    $display("[TB] wait timeout");
    applyStimulus(0, 200, 1, 0, 0);
    waitStart(20, "to", k);
    applyStimulus(1, 200, 1, 0, 0);
    n = 0;
    while (err_timeout_o !== 1'b1 && n < 5000) begin
      @(negedge sysClk);
      n++;
    end
    checkOutput("to_latency", 32'(n), 32'd4096);
    waitCycles(11);
    checkOutput("to_gap_busy", 32'(busy_o), 32'd1);
    waitCycles(1);
    checkOutput("to_idle_busy", 32'(busy_o), 32'd0);
    waitCycles(5);
    checkOutput("to_sticky", 32'(err_timeout_o), 32'd1);

    $display("[TB] asynchronous reset mid frame");
    applyStimulus(0, 200, 1, 0, 0);
    waitStart(20, "ar", k);
    applyStimulus(1, 200, 1, 0, 0);
    waitCycles(5);
    #2;
    sysRst = 1'b1;
    #1;
    checkOutput("ar_busy", 32'(busy_o), 32'd0);
    checkOutput("ar_start", 32'(start_o), 32'd0);
    checkOutput("ar_vframes", 32'(v_frames_o), 32'd0);
    checkOutput("ar_err", 32'(err_timeout_o), 32'd0);
    waitCycles(2);
    sysRst = 1'b0;
    applyStimulus(0, 200, 0, 10, 0);
    waitStart(10, "ar2", k);
    checkOutput("ar_first_tie", 32'(sel_o), 32'd0);
    checkOutput("ar_latency", 32'(k), 32'd1);
    waitCycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
